// File: rtl/rcvr_pkg.sv
// Shared types and helpers for the multi-lane serial frame receiver.
// Holds the control FSM encoding and the index-width helper used for port sizing.
package rcvr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rcvr_state_t;

    // Width of an index counting 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcvr_lane_shift.sv
// One lane's deserialising shift register; exposes the value it would hold after
// shifting in the current bit so the word can be captured on its final bit.
module rcvr_lane_shift
    import rcvr_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic              i_d,
    output logic [DATA_W-1:0] o_next
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_next;

    if (MSB_FIRST != 0) begin : g_msb
        assign w_next = {r_q[DATA_W-2:0], i_d};
    end else begin : g_lsb
        assign w_next = {i_d, r_q[DATA_W-1:1]};
    end

    assign o_next = w_next;

    // Shift register: clear on reset or frame restart, shift on sampled bits.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_next;
        end else begin
            r_q <= r_q;
        end
    end

endmodule

// File: rtl/rcvr_lanes.sv
// Multi-lane serial frame receiver: frame-sync driven bit/word counting shared by
// all lanes, one-cycle word strobes with sof/eof tags, and short-frame error detection.
module rcvr_lanes
    import rcvr_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LANES     = 2,
    parameter int WORDS     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_fs,
    input  logic [LANES-1:0]           i_d,
    output logic [LANES*DATA_W-1:0]    o_data,
    output logic                       o_vld,
    output logic [idx_w(WORDS)-1:0]    o_word_idx,
    output logic                       o_sof,
    output logic                       o_eof,
    output logic                       o_err,
    output logic                       o_busy
);

    localparam int                IDX_W     = idx_w(WORDS);
    localparam int                BIT_W     = idx_w(DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  WORD_LAST = IDX_W'(WORDS - 1);

    rcvr_state_t              r_state;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [IDX_W-1:0]         r_word_cnt;
    logic [LANES*DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]         r_word_idx;
    logic                     r_vld;
    logic                     r_sof;
    logic                     r_eof;
    logic                     r_err;
    logic [LANES*DATA_W-1:0]  w_next;
    logic                     w_sample;
    logic                     w_fresh;

    assign w_sample = (r_state == RECV) && !i_fs;
    // An i_fs seen before any bit was taken (e.g. i_fs held high) is a restart, not an error.
    assign w_fresh  = (r_bit_cnt == '0) && (r_word_cnt == '0);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        rcvr_lane_shift #(
            .DATA_W    (DATA_W),
            .MSB_FIRST (MSB_FIRST)
        ) u_shift (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_clr  (i_fs),
            .i_en   (w_sample),
            .i_d    (i_d[n]),
            .o_next (w_next[n*DATA_W +: DATA_W])
        );
    end

    // Control FSM, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_data     <= '0;
            r_word_idx <= '0;
            r_vld      <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_sof <= 1'b0;
            r_eof <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bit_cnt  <= '0;
                    r_word_cnt <= '0;
                    if (i_fs) begin
                        r_state <= RECV;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RECV: begin
                    if (i_fs) begin
                        r_err      <= !w_fresh;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end else if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt  <= '0;
                        r_data     <= w_next;
                        r_word_idx <= r_word_cnt;
                        r_vld      <= 1'b1;
                        r_sof      <= (r_word_cnt == '0);
                        r_eof      <= (r_word_cnt == WORD_LAST);
                        if (r_word_cnt == WORD_LAST) begin
                            r_state    <= IDLE;
                            r_word_cnt <= '0;
                        end else begin
                            r_word_cnt <= r_word_cnt + IDX_W'(1);
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_bit_cnt  <= '0;
                    r_word_cnt <= '0;
                end
            endcase
        end
    end

    assign o_data     = r_data;
    assign o_vld      = r_vld;
    assign o_word_idx = r_word_idx;
    assign o_sof      = r_sof;
    assign o_eof      = r_eof;
    assign o_err      = r_err;
    assign o_busy     = (r_state == RECV);

endmodule
